// File: rtl/seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative restoring divider producing one quotient bit per clock.
//            It divides a 2N-bit dividend by an N-bit divisor and returns a
//            2N-bit quotient and an N-bit remainder.
//            It uses the same Run-style start handshake as the multiplier.
// Ports    : Clk       - system clock, rising edge
//            Reset     - asynchronous active-high reset
//            Run       - start request, sampled only while idle
//            DVD       - 2N-bit dividend, captured on the start edge
//            DVS       - N-bit divisor, captured on the start edge
//            quotient  - 2N-bit quotient, valid from Done until next start
//            remainder - N-bit remainder, valid from Done until next start
//            Busy      - high while iterating
//            Done      - one-cycle pulse, results valid during it
//            DivZero   - set with Done when DVS was 0, held until next start
// Options  : DIVIDER_SIGNED_EN - two's complement operands and results.
//            The quotient truncates toward zero and the remainder takes the
//            dividend's sign. When the macro is undefined, all operands are
//            unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Run,
  input  logic [2*N-1:0] DVD,
  input  logic [N-1:0]   DVS,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           Busy,
  output logic           Done,
  output logic           DivZero
);

  localparam int              c_cw   = $clog2(2 * N);
  localparam logic [c_cw-1:0] c_last = c_cw'(2 * N - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_count;
  // The partial remainder is always below the divisor after each step, so
  // only N bits need storing. The N+1-bit value exists only combinationally,
  // after the shift.
  logic [N-1:0]    r_p;
  // The dividend shifts out of the top of this register while quotient bits
  // shift in at the bottom. After 2N steps, it holds the quotient.
  logic [2*N-1:0]  r_sr;
  logic [N-1:0]    r_dvs;

  logic [N:0]      w_shift;
  logic            w_ge;
  logic [N-1:0]    w_p_next;
  logic [2*N-1:0]  w_sr_next;
  logic [2*N-1:0]  w_dvd_mag;
  logic [N-1:0]    w_dvs_mag;
  logic [2*N-1:0]  w_q_fix;
  logic [N-1:0]    w_r_fix;

  // One restoring step: bring in the next dividend bit, then subtract the
  // divisor if it fits.
  assign w_shift   = {r_p, r_sr[2*N-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_p_next  = w_ge ? N'(w_shift - {1'b0, r_dvs}) : w_shift[N-1:0];
  assign w_sr_next = {r_sr[2*N-2:0], w_ge};

`ifdef DIVIDER_SIGNED_EN
  logic r_qneg;
  logic r_rneg;

  // Magnitudes feed the unsigned core. The most negative values map to
  // 2^(width-1), which still fits unsigned.
  assign w_dvd_mag = DVD[2*N-1] ? -DVD : DVD;
  assign w_dvs_mag = DVS[N-1]   ? -DVS : DVS;
  assign w_q_fix   = r_qneg ? -w_sr_next : w_sr_next;
  assign w_r_fix   = r_rneg ? -w_p_next  : w_p_next;
`else
  assign w_dvd_mag = DVD;
  assign w_dvs_mag = DVS;
  assign w_q_fix   = w_sr_next;
  assign w_r_fix   = w_p_next;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= c_idle;
      r_count   <= '0;
      r_p       <= '0;
      r_sr      <= '0;
      r_dvs     <= '0;
      quotient  <= '0;
      remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (Run) begin
            DivZero <= 1'b0;
            r_count <= '0;
            r_p     <= '0;
            if (DVS == '0) begin
              // A zero divisor is resolved right away and never iterates.
              quotient  <= '1;
              remainder <= DVD[N-1:0];
              DivZero   <= 1'b1;
              Done      <= 1'b1;
              r_state   <= c_done;
            end else begin
              r_sr    <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              Busy    <= 1'b1;
              r_state <= c_calc;
`ifdef DIVIDER_SIGNED_EN
              r_qneg  <= DVD[2*N-1] ^ DVS[N-1];
              r_rneg  <= DVD[2*N-1];
`endif
            end
          end
        end

        c_calc: begin
          r_p     <= w_p_next;
          r_sr    <= w_sr_next;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            // The last step is registered straight into the outputs, so
            // results become visible together with Done.
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            r_state   <= c_done;
          end
        end

        c_done: begin
          r_state <= c_idle;
        end

        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Scoreboard testbench for seq_divider.
//            The stimulus side pushes expected results, computed with plain
//            integer division. A negedge monitor pops an entry and compares
//            it whenever Done is presented.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [31:0] DVD;
  logic [15:0] DVS;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  seq_divider #(.N(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .DVD       (DVD),
    .DVS       (DVS),
    .quotient  (quotient),
    .remainder (remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division. Signed SV division truncates toward
  // zero and the remainder follows the dividend.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int at);
    exp_t   e;
    longint x;
    longint y;
    e.at = at;
    e.dz = (b == 16'd0);
    if (b == 16'd0) begin
      e.q = '1;
      e.r = a[15:0];
    end else begin
`ifdef DIVIDER_SIGNED_EN
      x = longint'($signed(a));
      y = longint'($signed(b));
`else
      x = longint'(a);
      y = longint'(b);
`endif
      e.q = 32'(x / y);
      e.r = 16'(x % y);
    end
    return e;
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {63'd0, Done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient",     {32'd0, quotient},  {32'd0, mon_e.q});
        chk("remainder",    {48'd0, remainder}, {48'd0, mon_e.r});
        chk("divzero",      {63'd0, DivZero},   {63'd0, mon_e.dz});
        chk("done_cycle",   64'(cyc),           64'(mon_e.at));
        chk("busy_at_done", {63'd0, Busy},      64'd0);
      end
    end
  end

  // Must be called at a negedge. It counts Busy cycles until Done is seen.
  task automatic wait_done(output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      if (Busy) bc = bc + 1;
      @(negedge Clk);
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [15:0] b);
    int s;
    int bc;
    bit ok;
    @(negedge Clk);
    Run = 1'b1;
    DVD = a;
    DVS = b;
    @(posedge Clk);
    #1;
    s   = cyc;
    Run = 1'b0;
    // Scrambled inputs must not disturb the captured operands.
    DVD = $urandom;
    DVS = 16'($urandom);
    sb.push_back(model(a, b, (b == 16'd0) ? s : s + 32));
    chk("busy_after_start", {63'd0, Busy}, {63'd0, (b != 16'd0)});
    @(negedge Clk);
    wait_done(bc, ok);
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
    chk("busy_cycles", 64'(bc), (b == 16'd0) ? 64'd0 : 64'd32);
    @(negedge Clk);
    chk("done_pulse_width", {63'd0, Done}, 64'd0);
  endtask

  initial begin
    int s;
    int bc;
    bit ok;
    logic [31:0] ra;
    logic [15:0] rb;
    int sel;

    Reset = 1'b1;
    Run   = 1'b0;
    DVD   = '0;
    DVS   = '0;
    #12;
    chk("rst_quotient",  {32'd0, quotient},  64'd0);
    chk("rst_remainder", {48'd0, remainder}, 64'd0);
    chk("rst_busy",      {63'd0, Busy},      64'd0);
    chk("rst_done",      {63'd0, Done},      64'd0);
    chk("rst_divzero",   {63'd0, DivZero},   64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed cases
    do_div(32'h0000_1000, 16'h0030);
    do_div(32'hFFFF_FFFF, 16'h0001);
    do_div(32'hFFFF_FFFF, 16'hFFFF);
    do_div(32'h0000_0064, 16'h0000);
    do_div(32'h0000_1000, 16'h0030);   // DivZero must clear on the next start

    // Run held high: two back-to-back divisions, with DVD changed mid-run
    @(negedge Clk);
    Run = 1'b1;
    DVD = 32'd5;
    DVS = 16'd7;
    @(posedge Clk);
    #1;
    s = cyc;
    sb.push_back(model(32'd5, 16'd7, s + 32));
    sb.push_back(model(32'd9, 16'd7, s + 34 + 32));
    repeat (10) @(negedge Clk);
    DVD = 32'd9;
    for (int i = 0; i < 100 && cyc < s + 34; i++) @(negedge Clk);
    Run = 1'b0;
    chk("b2b_second_busy", {63'd0, Busy}, 64'd1);
    wait_done(bc, ok);
    if (!ok) chk("b2b_timeout", 64'd0, 64'd1);
    chk("b2b_busy_cycles", 64'(bc), 64'd32);
    @(negedge Clk);

    // Asynchronous reset partway through an operation
    @(negedge Clk);
    Run = 1'b1;
    DVD = 32'h0000_1000;
    DVS = 16'h0030;
    @(posedge Clk);
    #1;
    Run = 1'b0;
    repeat (10) @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_busy",      {63'd0, Busy},      64'd0);
    chk("abort_done",      {63'd0, Done},      64'd0);
    chk("abort_quotient",  {32'd0, quotient},  64'd0);
    chk("abort_remainder", {48'd0, remainder}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("abort_idle_busy", {63'd0, Busy}, 64'd0);
    do_div(32'h0000_1000, 16'h0030);

    // Sign-sensitive operands; the model interprets them per the build
    do_div(32'hFFFF_FF9C, 16'h0007);
    do_div(32'h8000_0000, 16'hFFFF);
    do_div(32'h8000_0000, 16'h8000);
    do_div(32'h0000_0007, 16'hFFF9);

    // Randomised operands
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      if (sel == 0)      rb = 16'd0;
      else if (sel < 4)  rb = 16'($urandom_range(1, 300));
      else               rb = 16'($urandom);
      if (sel == 7)      ra = $urandom_range(0, 5000);
      do_div(ra, rb);
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
